// File: rtl/instr_fetch.sv
// Fetch/sequencing unit: owns the program counter, applies taken branches,
// runs the Start/Done handshake and counts RUN cycles for benchmarking.
module instr_fetch #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 1023,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             InstValid,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = START_ADDR[PC_W-1:0];
  localparam logic [31:0]      LAST_PC  = LAST_ADDR;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state;
  logic   atLast;

  // Compared at full 32-bit width so a LAST_ADDR beyond the ROM never matches
  assign atLast = (32'(ProgCtr) == LAST_PC);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ProgCtr    <= START_PC;
      CycleCount <= '0;
      InstValid  <= 1'b0;
      Done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ProgCtr <= START_PC;
          if (Start) begin
            state      <= RUN;
            CycleCount <= '0;
            InstValid  <= 1'b1;
          end
        end
        RUN: begin
          if (CycleCount != CNT_MAX)
            CycleCount <= CycleCount + CNT_W'(1);
          // Halt and the final address win over any branch in the same cycle
          if (Halt || atLast) begin
            state     <= DONE;
            InstValid <= 1'b0;
            Done      <= 1'b1;
          end else if (BranchEn && Zero) begin
            ProgCtr <= Target;
          end else begin
            ProgCtr <= ProgCtr + PC_W'(1);
          end
        end
        DONE: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= START_PC;
            CycleCount <= '0;
            InstValid  <= 1'b1;
            Done       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          InstValid <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: three instances cover straight-line, branch/halt
// and wrap/saturate behaviour; a negedge monitor pops expected PCs and run results.
module tb_instr_fetch;

  typedef struct {
    bit isDone;
    int pc;
    int cnt;
  } exp_t;

  logic Clk;
  logic Reset_n;
  logic startIn[3];
  logic branchIn[3];
  logic zeroIn[3];
  logic haltIn[3];
  logic [9:0] tgtA;
  logic [2:0] tgtB;
  logic [9:0] tgtC;

  logic [9:0]  pcA;
  logic [2:0]  pcB;
  logic [9:0]  pcC;
  logic [15:0] cntA;
  logic [2:0]  cntB;
  logic [15:0] cntC;
  logic        validA, validB, validC;
  logic        doneA, doneB, doneC;

  exp_t expQ[3][$];
  bit   prevDone[3];
  int   compared;
  int   mismatched;

  // A: short program ending at address 5
  instr_fetch #(.PC_W(10), .START_ADDR(0), .LAST_ADDR(5), .CNT_W(16)) dutA (
    .Clk(Clk), .Reset_n(Reset_n), .Start(startIn[0]), .BranchEn(branchIn[0]),
    .Zero(zeroIn[0]), .Target(tgtA), .Halt(haltIn[0]), .ProgCtr(pcA),
    .InstValid(validA), .Done(doneA), .CycleCount(cntA)
  );

  // B: tiny PC and counter to exercise wrap and saturation
  instr_fetch #(.PC_W(3), .START_ADDR(0), .LAST_ADDR(1023), .CNT_W(3)) dutB (
    .Clk(Clk), .Reset_n(Reset_n), .Start(startIn[1]), .BranchEn(branchIn[1]),
    .Zero(zeroIn[1]), .Target(tgtB), .Halt(haltIn[1]), .ProgCtr(pcB),
    .InstValid(validB), .Done(doneB), .CycleCount(cntB)
  );

  // C: default sizing for branch and halt priority
  instr_fetch #(.PC_W(10), .START_ADDR(0), .LAST_ADDR(1023), .CNT_W(16)) dutC (
    .Clk(Clk), .Reset_n(Reset_n), .Start(startIn[2]), .BranchEn(branchIn[2]),
    .Zero(zeroIn[2]), .Target(tgtC), .Halt(haltIn[2]), .ProgCtr(pcC),
    .InstValid(validC), .Done(doneC), .CycleCount(cntC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expPc(input int d, input int pc);
    exp_t e;
    e.isDone = 1'b0;
    e.pc     = pc;
    e.cnt    = 0;
    expQ[d].push_back(e);
  endtask

  task automatic expDone(input int d, input int pc, input int cnt);
    exp_t e;
    e.isDone = 1'b1;
    e.pc     = pc;
    e.cnt    = cnt;
    expQ[d].push_back(e);
  endtask

  // Drive one cycle of inputs to instance d (others idle), then advance past the edge
  task automatic applyStimulus(input int d, input bit s, input bit br, input bit z,
                               input int tgt, input bit h);
    for (int i = 0; i < 3; i++) begin
      startIn[i]  = 1'b0;
      branchIn[i] = 1'b0;
      zeroIn[i]   = 1'b0;
      haltIn[i]   = 1'b0;
    end
    tgtA = '0;
    tgtB = '0;
    tgtC = '0;
    startIn[d]  = s;
    branchIn[d] = br;
    zeroIn[d]   = z;
    haltIn[d]   = h;
    case (d)
      0:       tgtA = 10'(tgt);
      1:       tgtB = 3'(tgt);
      default: tgtC = 10'(tgt);
    endcase
    @(posedge Clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic monitorOne(input int d, input bit valid, input bit done,
                            input int pc, input int cnt);
    exp_t e;
    if (valid) begin
      if (expQ[d].size() == 0) begin
        checkOutput($sformatf("dut%0d_unexpected_valid_pc", d), pc, -1);
      end else begin
        e = expQ[d].pop_front();
        checkOutput($sformatf("dut%0d_entry_kind", d), 0, int'(e.isDone));
        checkOutput($sformatf("dut%0d_pc", d), pc, e.pc);
      end
    end
    if (done && !prevDone[d]) begin
      if (expQ[d].size() == 0) begin
        checkOutput($sformatf("dut%0d_unexpected_done", d), 1, 0);
      end else begin
        e = expQ[d].pop_front();
        checkOutput($sformatf("dut%0d_done_kind", d), 1, int'(e.isDone));
        checkOutput($sformatf("dut%0d_done_pc", d), pc, e.pc);
        checkOutput($sformatf("dut%0d_done_count", d), cnt, e.cnt);
      end
    end
    prevDone[d] = done;
  endtask

  always @(negedge Clk) begin
    monitorOne(0, validA, doneA, int'(pcA), int'(cntA));
    monitorOne(1, validB, doneB, int'(pcB), int'(cntB));
    monitorOne(2, validC, doneC, int'(pcC), int'(cntC));
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, int'(pcA), 0);
    checkOutput({tag, "_valid"}, int'(validA), 0);
    checkOutput({tag, "_done"}, int'(doneA), 0);
    checkOutput({tag, "_count"}, int'(cntA), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 3; i++) begin
      startIn[i]  = 1'b0;
      branchIn[i] = 1'b0;
      zeroIn[i]   = 1'b0;
      haltIn[i]   = 1'b0;
      prevDone[i] = 1'b0;
    end
    tgtA    = '0;
    tgtB    = '0;
    tgtC    = '0;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1 checkResetState("power_on_reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Straight line on A: 0..5 then DONE with 6 RUN cycles
    expPc(0, 0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int p = 1; p <= 5; p++) begin
      expPc(0, p);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    expDone(0, 5, 6);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idleCycles(2);

    // Branch taken / not taken on C, ending with a plain halt
    expPc(2, 0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int p = 1; p <= 3; p++) begin
      expPc(2, p);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    expPc(2, 40);
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    expPc(2, 41);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    expPc(2, 3);
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    expPc(2, 4);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 40, 1'b0);
    expDone(2, 4, 8);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idleCycles(2);

    // Halt beats a taken branch at PC 7
    expPc(2, 0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int p = 1; p <= 7; p++) begin
      expPc(2, p);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    expDone(2, 7, 8);
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 40, 1'b1);
    idleCycles(2);

    // Wrap 7 -> 0 and counter saturation on B: 10 RUN cycles saturate at 7
    expPc(1, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      expPc(1, i % 8);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    expDone(1, 1, 7);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idleCycles(2);

    // Restart A from DONE; a Start pulse mid-run is ignored
    expPc(0, 0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("restart_pc", int'(pcA), 0);
    checkOutput("restart_count", int'(cntA), 0);
    checkOutput("restart_done", int'(doneA), 0);
    checkOutput("restart_valid", int'(validA), 1);
    expPc(0, 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    expPc(0, 2);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int p = 3; p <= 5; p++) begin
      expPc(0, p);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    expDone(0, 5, 6);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idleCycles(2);
    checkOutput("done_hold_pc", int'(pcA), 5);
    checkOutput("done_hold_count", int'(cntA), 6);

    // Asynchronous reset between clock edges while A sits in DONE
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 checkResetState("async_reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    idleCycles(3);

    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("dut%0d_leftover_expected", d), expQ[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
